sound_wave_gen: RTL and testbench

Parametrised wave-table channel: generalises the channel-3 wave player with configurable sample width, wave-RAM depth, frequency and length widths. It owns its wave RAM behind a CPU byte port, steps through it at a programmable rate, applies a shift-volume, and gates output with DAC-enable, length expiry and trigger logic. It sits between the APU register file and the mixer, one instance per wave channel.

---
 rtl/sound_wave_gen.sv | 151 +++++++++++++++
 tb/tb_sound_wave_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_wave_gen.sv
// Wave-table sound channel: CPU-owned wave RAM, rate timer, length counter, shift volume.
// Define SOUND_WAVE_RAMLOCK_EN to lock the CPU port to the playing word while active.
module sound_wave_gen #(
    parameter int unsigned SAMPLE_W   = 4,
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned FREQ_W     = 11,
    parameter int unsigned LEN_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_we,
    input  logic [DEPTH_LOG2-2:0]   cpu_addr,
    input  logic [2*SAMPLE_W-1:0]   cpu_wdata,
    output logic [2*SAMPLE_W-1:0]   cpu_rdata,
    input  logic                    trigger,
    input  logic                    dac_en,
    input  logic                    single,
    input  logic                    length_tick,
    input  logic [LEN_W-1:0]        length,
    input  logic [1:0]              volume,
    input  logic [FREQ_W-1:0]       frequency,
    output logic [SAMPLE_W-1:0]     level,
    output logic                    active,
    output logic [DEPTH_LOG2-1:0]   position
);

    localparam int unsigned Words = 2 ** (DEPTH_LOG2 - 1);

    logic [2*SAMPLE_W-1:0] r_ram [Words];

    logic [FREQ_W:0]       r_timer;
    logic [LEN_W:0]        r_len;
    logic [DEPTH_LOG2-1:0] r_pos;
    logic [SAMPLE_W-1:0]   r_buf;
    logic                  r_active;
    logic [SAMPLE_W-1:0]   r_level;
    logic [2*SAMPLE_W-1:0] r_rdata;

    logic [FREQ_W:0]       w_timer_d;
    logic [LEN_W:0]        w_len_d;
    logic [DEPTH_LOG2-1:0] w_pos_d;
    logic [SAMPLE_W-1:0]   w_buf_d;
    logic                  w_active_d;
    logic [SAMPLE_W-1:0]   w_level_d;
    logic [SAMPLE_W-1:0]   w_shifted;

    logic [FREQ_W:0]       w_reload;
    logic                  w_wrap;
    logic                  w_tick;
    logic                  w_expire;
    logic                  w_advance;
    logic [LEN_W:0]        w_len_load;
    logic [DEPTH_LOG2-1:0] w_pos_next;
    logic [2*SAMPLE_W-1:0] w_fetch_word;
    logic [SAMPLE_W-1:0]   w_fetch_smp;
    logic                  w_ram_we;
    logic [DEPTH_LOG2-2:0] w_rd_addr;

    assign w_reload    = {frequency, 1'b0};
    assign w_wrap      = &r_timer;
    assign w_tick      = single & length_tick & (r_len != '0);
    assign w_expire    = w_tick & (r_len == (LEN_W+1)'(1));
    assign w_len_load  = (LEN_W+1)'(2 ** LEN_W) - {1'b0, length};
    assign w_advance   = ~trigger & dac_en & ~w_expire & w_wrap & r_active;
    assign w_pos_next  = r_pos + DEPTH_LOG2'(1);

    // Fetch reads the pre-write RAM contents, so a same-cycle write to this word is not seen.
    assign w_fetch_word = r_ram[w_pos_next[DEPTH_LOG2-1:1]];
    assign w_fetch_smp  = w_pos_next[0] ? w_fetch_word[SAMPLE_W-1:0]
                                        : w_fetch_word[2*SAMPLE_W-1:SAMPLE_W];

`ifdef SOUND_WAVE_RAMLOCK_EN
    assign w_ram_we  = cpu_we & ~r_active;
    assign w_rd_addr = r_active ? r_pos[DEPTH_LOG2-1:1] : cpu_addr;
`else
    assign w_ram_we  = cpu_we;
    assign w_rd_addr = cpu_addr;
`endif

    always_comb begin
        w_timer_d  = r_timer + (FREQ_W+1)'(1);
        w_len_d    = r_len;
        w_pos_d    = r_pos;
        w_buf_d    = r_buf;
        w_active_d = r_active;
        if (trigger) begin
            w_timer_d  = w_reload;
            w_len_d    = w_len_load;
            w_pos_d    = '0;
            w_active_d = dac_en;
        end else begin
            if (w_wrap) begin
                w_timer_d = w_reload;
            end
            if (w_tick) begin
                w_len_d = r_len - (LEN_W+1)'(1);
            end
            if (!dac_en || w_expire) begin
                w_active_d = 1'b0;
            end
            if (w_advance) begin
                w_pos_d = w_pos_next;
                w_buf_d = w_fetch_smp;
            end
        end
    end

    always_comb begin
        w_shifted = '0;
        unique case (volume)
            2'd0: w_shifted = '0;
            2'd1: w_shifted = w_buf_d;
            2'd2: w_shifted = w_buf_d >> 1;
            2'd3: w_shifted = w_buf_d >> 2;
        endcase
        w_level_d = w_active_d ? w_shifted : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timer  <= '0;
            r_len    <= '0;
            r_pos    <= '0;
            r_buf    <= '0;
            r_active <= 1'b0;
            r_level  <= '0;
            r_rdata  <= '0;
        end else begin
            r_timer  <= w_timer_d;
            r_len    <= w_len_d;
            r_pos    <= w_pos_d;
            r_buf    <= w_buf_d;
            r_active <= w_active_d;
            r_level  <= w_level_d;
            r_rdata  <= r_ram[w_rd_addr];
        end
    end

    // Wave RAM has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[cpu_addr] <= cpu_wdata;
        end
    end

    assign cpu_rdata = r_rdata;
    assign level     = r_level;
    assign active    = r_active;
    assign position  = r_pos;

endmodule

// File: tb/tb_sound_wave_gen.sv
// Self-checking bench for sound_wave_gen: directed sequences, a volume table and random
// stimulus compared every cycle against a sample-indexed behavioural model.
module tb_sound_wave_gen;

    localparam int TMax = 4095;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_we;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       trigger;
    logic       dac_en;
    logic       single;
    logic       length_tick;
    logic [7:0] length;
    logic [1:0] volume;
    logic [10:0] frequency;
    logic [3:0] level;
    logic       active;
    logic [4:0] position;

    always #5 clk = ~clk;

    sound_wave_gen dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .trigger     (trigger),
        .dac_en      (dac_en),
        .single      (single),
        .length_tick (length_tick),
        .length      (length),
        .volume      (volume),
        .frequency   (frequency),
        .level       (level),
        .active      (active),
        .position    (position)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: RAM held as individual samples, timer as cycles left until the next step.
    int m_smp [32];
    int m_pos, m_buf, m_active, m_len, m_left, m_level, m_rdata;
    bit chk_rd = 1'b0;

    typedef struct {
        logic [1:0] vol;
        logic [3:0] exp_level;
    } vol_vec_t;
    vol_vec_t vtab [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  old_smp [32];
        int  ra;
        int  v;
        bit  wr_ok;
        bit  wrap;
        bit  expire;
        old_smp = m_smp;
        if (!rst) begin
            m_pos = 0; m_buf = 0; m_active = 0; m_len = 0;
            m_left = TMax; m_level = 0; m_rdata = 0;
        end else begin
            ra    = int'(cpu_addr);
            wr_ok = cpu_we;
`ifdef SOUND_WAVE_RAMLOCK_EN
            if (m_active != 0) begin
                ra    = m_pos / 2;
                wr_ok = 1'b0;
            end
`endif
            m_rdata = old_smp[2*ra] * 16 + old_smp[2*ra+1];
            if (trigger) begin
                m_pos    = 0;
                m_len    = 256 - int'(length);
                m_active = int'(dac_en);
                m_left   = TMax - 2 * int'(frequency);
            end else begin
                wrap   = (m_left == 0);
                expire = 1'b0;
                m_left = wrap ? TMax - 2 * int'(frequency) : m_left - 1;
                if (single && length_tick && m_len != 0) begin
                    m_len--;
                    expire = (m_len == 0);
                end
                if (!dac_en || expire) begin
                    m_active = 0;
                end else if (wrap && m_active != 0) begin
                    m_pos = (m_pos + 1) % 32;
                    m_buf = old_smp[m_pos];
                end
            end
            v = int'(volume);
            m_level = (m_active == 0 || v == 0) ? 0 : (m_buf >> (v - 1));
            if (wr_ok) begin
                m_smp[2*int'(cpu_addr)]   = int'(cpu_wdata[7:4]);
                m_smp[2*int'(cpu_addr)+1] = int'(cpu_wdata[3:0]);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("level", 32'(level), m_level);
        chk("active", 32'(active), m_active);
        chk("position", 32'(position), m_pos);
        if (chk_rd) chk("cpu_rdata", 32'(cpu_rdata), m_rdata);
    endtask

    task automatic write_word(input int a, input int d);
        cpu_we = 1'b1; cpu_addr = 4'(a); cpu_wdata = 8'(d);
        cyc();
        cpu_we = 1'b0;
    endtask

    initial begin
        int n;
        vtab[0] = '{2'd1, 4'hD};
        vtab[1] = '{2'd2, 4'h6};
        vtab[2] = '{2'd3, 4'h3};
        vtab[3] = '{2'd0, 4'h0};
        vtab[4] = '{2'd1, 4'hD};
        for (int i = 0; i < 32; i++) m_smp[i] = 0;

        rst = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; trigger = 1'b0;
        dac_en = 1'b0; single = 1'b0; length_tick = 1'b0; length = '0; volume = 2'd1;
        frequency = '0;
        repeat (3) cyc();
        chk("reset_level", 32'(level), 0);
        chk("reset_active", 32'(active), 0);
        chk("reset_position", 32'(position), 0);
        chk("reset_rdata", 32'(cpu_rdata), 0);
        rst = 1'b1;

        // Ramp pattern: sample i holds i mod 16
        for (int w = 0; w < 16; w++) write_word(w, ((2*w) % 16) * 16 + (2*w + 1) % 16);
        cyc();
        chk_rd = 1'b1;

        // Fastest rate: one step every 2 clocks, first played sample is index 1
        frequency = 11'd2047; dac_en = 1'b1; volume = 2'd1; trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        chk("trig_position", 32'(position), 0);
        chk("trig_active", 32'(active), 1);
        chk("trig_level", 32'(level), 0);
        for (int k = 1; k <= 40; k++) begin
            cyc(); cyc();
            chk("ramp_position", 32'(position), k % 32);
            chk("ramp_level", 32'(level), k % 16);
        end

        // Step period at the slowest and a near-fastest setting
        frequency = 11'd0; trigger = 1'b1; cyc(); trigger = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (position == 5'd0 && n < 5000);
        chk("period_f0", n, 4096);
        frequency = 11'd2046; trigger = 1'b1; cyc(); trigger = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (position == 5'd0 && n < 100);
        chk("period_f2046", n, 4);

        // Volume table on a constant 0xD sample, slow timer so the sample holds
        dac_en = 1'b0; cyc();
        for (int w = 0; w < 16; w++) write_word(w, 8'hDD);
        dac_en = 1'b1; frequency = 11'd2047; trigger = 1'b1; cyc(); trigger = 1'b0;
        repeat (4) cyc();
        frequency = 11'd0; trigger = 1'b1; cyc(); trigger = 1'b0;
        for (int i = 0; i < 5; i++) begin
            volume = vtab[i].vol;
            cyc();
            chk("volume_level", 32'(level), 32'(vtab[i].exp_level));
        end

        // Length counter: 254 -> two ticks, 0 -> 256 ticks
        single = 1'b1; length = 8'd254; trigger = 1'b1; cyc(); trigger = 1'b0;
        length_tick = 1'b1;
        cyc();
        chk("len254_tick1_active", 32'(active), 1);
        cyc();
        chk("len254_tick2_active", 32'(active), 0);
        chk("len254_tick2_level", 32'(level), 0);
        length_tick = 1'b0;
        length = 8'd0; trigger = 1'b1; cyc(); trigger = 1'b0;
        length_tick = 1'b1;
        repeat (255) cyc();
        chk("len0_tick255_active", 32'(active), 1);
        cyc();
        chk("len0_tick256_active", 32'(active), 0);
        length_tick = 1'b0; single = 1'b0;

        // DAC power off
        frequency = 11'd2047; trigger = 1'b1; cyc(); trigger = 1'b0;
        repeat (3) cyc();
        dac_en = 1'b0;
        cyc();
        chk("dacoff_active", 32'(active), 0);
        chk("dacoff_level", 32'(level), 0);
        trigger = 1'b1; cyc(); trigger = 1'b0;
        chk("trig_dacoff_active", 32'(active), 0);
        chk("trig_dacoff_position", 32'(position), 0);

        // CPU write while playing word 0
        dac_en = 1'b1; frequency = 11'd0; trigger = 1'b1; cyc(); trigger = 1'b0;
        write_word(5, 8'hA5);
        cpu_addr = 4'd5;
        cyc();
`ifdef SOUND_WAVE_RAMLOCK_EN
        chk("play_read", 32'(cpu_rdata), 32'h00DD);
`else
        chk("play_read", 32'(cpu_rdata), 32'h00A5);
`endif

        // Reset mid-playback leaves RAM intact
        frequency = 11'd2047; trigger = 1'b1; cyc(); trigger = 1'b0;
        repeat (5) cyc();
        rst = 1'b0;
        cyc();
        chk("midrst_position", 32'(position), 0);
        chk("midrst_active", 32'(active), 0);
        chk("midrst_level", 32'(level), 0);
        chk("midrst_rdata", 32'(cpu_rdata), 0);
        rst = 1'b1; cpu_addr = 4'd5;
        cyc();
`ifdef SOUND_WAVE_RAMLOCK_EN
        chk("midrst_ram", 32'(cpu_rdata), 32'h00DD);
`else
        chk("midrst_ram", 32'(cpu_rdata), 32'h00A5);
`endif

        // Random traffic against the model
        for (int c = 0; c < 6000; c++) begin
            rst         = ($urandom % 700) != 0;
            cpu_we      = rst && (($urandom % 6) == 0);
            cpu_addr    = 4'($urandom);
            cpu_wdata   = 8'($urandom);
            trigger     = ($urandom % 40) == 0;
            dac_en      = ($urandom % 60) != 0;
            single      = ($urandom % 3) != 0;
            length_tick = ($urandom % 3) == 0;
            length      = ($urandom % 2) ? 8'($urandom_range(240, 255)) : 8'($urandom);
            volume      = 2'($urandom);
            frequency   = 11'($urandom_range(2040, 2047));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
